// File: rtl/tensor_pkg.sv
// tensor_pkg: shared state/op encodings, size defaults and saturation limits for tensor_engine.
package tensor_pkg;
    localparam int DIM_DEF = 2;
    localparam int W_DEF   = 16;
    localparam logic [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOAD_LAST, S_MAC, S_WRITE, S_DONE, S_RELEASE
    } state_t;

    typedef enum logic [1:0] {OP_LOAD_A, OP_LOAD_B, OP_STORE} op_t;
endpackage

// File: rtl/tensor_mac.sv
// tensor_mac: signed multiply-accumulate with clear/enable; result optionally saturated
// to the signed W-bit range when TENSOR_SATURATE_EN is defined, otherwise wrapped.
module tensor_mac
    import tensor_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int ACCW = 2*W + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [W-1:0]    a,
    input  logic signed [W-1:0]    b,
    output logic signed [ACCW-1:0] acc,
    output logic        [W-1:0]    result
);
    logic signed [2*W-1:0] prod;

    assign prod = a * b;

    // clr restarts the sum with this cycle's product rather than zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (en)
            acc <= (clr ? '0 : acc) + ACCW'(prod);
    end

`ifdef TENSOR_SATURATE_EN
    logic ovf;
    assign ovf    = acc[ACCW-1:W-1] != {(ACCW-W+1){acc[ACCW-1]}};
    assign result = !ovf ? acc[W-1:0] :
                    acc[ACCW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    assign result = acc[W-1:0];
`endif
endmodule

// File: rtl/tensor_engine.sv
// tensor_engine: loads A/B tensors from memory, stores C = A x B, pulses done to release the CPU stall.
// Saturating write-back is selected with TENSOR_SATURATE_EN (see tensor_mac).
module tensor_engine
    import tensor_pkg::*;
#(
    parameter int DIM = DIM_DEF,
    parameter int W   = W_DEF,
    parameter int AW  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_a,
    input  logic          load_b,
    input  logic          store_tensor,
    input  logic          str_tensor_rez,
    input  logic [AW-1:0] tensor_addr,
    output logic          tensor_op_done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [W-1:0]  mem_rdata,
    output logic          mem_wr,
    output logic [W-1:0]  mem_wdata,
    output logic [W-1:0]  tensor_rez
);
    localparam int N    = DIM * DIM;
    localparam int NW   = $clog2(N);
    localparam int ACCW = 2*W + $clog2(DIM);
    localparam logic [NW-1:0] DIMN  = NW'(DIM);
    localparam logic [NW-1:0] DLAST = NW'(DIM - 1);
    localparam logic [NW-1:0] NLAST = NW'(N - 1);

    state_t                 state;
    op_t                    op;
    logic [AW-1:0]          base;
    logic [NW-1:0]          i, row, col, k, wi;
    logic [W-1:0]           checksum, result;
    logic signed [W-1:0]    a_t [N];
    logic signed [W-1:0]    b_t [N];
    logic signed [ACCW-1:0] mac_acc_unused;
    logic                   cap, req, st;

    tensor_mac #(.W(W), .ACCW(ACCW)) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (k == '0),
        .en      (state == S_MAC),
        .a       (a_t[row*DIMN + k]),
        .b       (b_t[k*DIMN + col]),
        .acc     (mac_acc_unused),
        .result  (result)
    );

    // read data lags the strobe by one cycle, so LOAD captures element i-1
    assign cap = (state == S_LOAD_LAST) || (state == S_LOAD && i != '0);
    assign wi  = (state == S_LOAD_LAST) ? i : i - 1'b1;
    assign req = load_a | load_b | store_tensor;
    assign st  = store_tensor & ~load_a & ~load_b;

    assign busy           = state != S_IDLE;
    assign tensor_op_done = state == S_DONE;
    assign mem_rd         = state == S_LOAD;
    assign mem_wr         = state == S_WRITE;
    assign mem_addr       = (mem_rd | mem_wr) ? base + AW'(i) : '0;
    assign mem_wdata      = mem_wr ? result : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op         <= OP_LOAD_A;
            base       <= '0;
            i          <= '0;
            row        <= '0;
            col        <= '0;
            k          <= '0;
            checksum   <= '0;
            tensor_rez <= '0;
            for (int j = 0; j < N; j++) begin
                a_t[j] <= '0;
                b_t[j] <= '0;
            end
        end else begin
            if (cap) begin
                if (op == OP_LOAD_A) a_t[wi] <= mem_rdata;
                else                 b_t[wi] <= mem_rdata;
            end
            case (state)
                S_IDLE: begin
                    if (str_tensor_rez) tensor_rez <= checksum;
                    if (req) begin
                        base  <= tensor_addr;
                        op    <= load_b ? OP_LOAD_B : load_a ? OP_LOAD_A : OP_STORE;
                        i     <= '0;
                        row   <= '0;
                        col   <= '0;
                        k     <= '0;
                        state <= st ? S_MAC : S_LOAD;
                        if (st) checksum <= '0;
                    end
                end
                S_LOAD: begin
                    if (i == NLAST) state <= S_LOAD_LAST;
                    else            i     <= i + 1'b1;
                end
                S_LOAD_LAST: state <= S_DONE;
                S_MAC: begin
                    k     <= (k == DLAST) ? '0 : k + 1'b1;
                    state <= (k == DLAST) ? S_WRITE : S_MAC;
                end
                S_WRITE: begin
                    checksum <= checksum + result;
                    if (i == NLAST) begin
                        state <= S_DONE;
                    end else begin
                        i     <= i + 1'b1;
                        col   <= (col == DLAST) ? '0 : col + 1'b1;
                        row   <= (col == DLAST) ? row + 1'b1 : row;
                        state <= S_MAC;
                    end
                end
                S_DONE:    state <= S_RELEASE;
                S_RELEASE: if (!req) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tensor_engine.sv
// tb_tensor_engine: randomized self-checking bench; a flat memory model feeds the engine and
// expected C values/checksums come from plain matrix arithmetic on the tensors it was given.
module tb_tensor_engine;
    localparam int DIM = 2;
    localparam int N   = DIM * DIM;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        load_a = 1'b0, load_b = 1'b0, store_tensor = 1'b0, str_tensor_rez = 1'b0;
    logic [15:0] tensor_addr = '0, mem_rdata = '0;
    logic [15:0] mem_addr, mem_wdata, tensor_rez;
    logic        tensor_op_done, busy, mem_rd, mem_wr;

    logic [15:0]        mem [65536];
    logic [15:0]        reads [$];
    logic [31:0]        writes [$];
    int                 wcyc [$];
    int                 cyc_cnt = 0, both = 0;
    logic signed [15:0] ra [N], rb [N];
    logic [15:0]        chk;
    int                 checks = 0, errors = 0;

    always #5 clk = ~clk;

    tensor_engine dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_a         (load_a),
        .load_b         (load_b),
        .store_tensor   (store_tensor),
        .str_tensor_rez (str_tensor_rez),
        .tensor_addr    (tensor_addr),
        .tensor_op_done (tensor_op_done),
        .busy           (busy),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .tensor_rez     (tensor_rez)
    );

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            reads.push_back(mem_addr);
        end
        if (mem_wr) begin
            writes.push_back({mem_addr, mem_wdata});
            wcyc.push_back(cyc_cnt);
        end
        if (mem_rd && mem_wr) both <= both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_c(int e);
        longint s = 0;
        int r = e / DIM;
        int c = e % DIM;
        for (int kk = 0; kk < DIM; kk++) s += longint'(ra[r*DIM+kk]) * longint'(rb[kk*DIM+c]);
`ifdef TENSOR_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    task automatic put(input logic [15:0] addr, input logic [15:0] v [N]);
        for (int e = 0; e < N; e++) mem[16'(addr + e)] = v[e];
    endtask

    task automatic run_op(input int kind, input logic [15:0] addr, input int hold, output int lat);
        int cyc, ndone, r0;
        @(negedge clk);
        tensor_addr  = addr;
        load_a       = (kind == 0 || kind == 3);
        load_b       = (kind == 1 || kind == 3);
        store_tensor = (kind == 2);
        lat = -1;
        cyc = 0;
        while (lat < 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (tensor_op_done) lat = cyc;
        end
        check("done_seen", 32'(lat > 0), 32'd1);
        ndone = 0;
        r0 = reads.size();
        repeat (hold) begin
            @(negedge clk);
            ndone += int'(tensor_op_done);
        end
        if (hold > 0) begin
            check("held_no_redone", 32'(ndone), 32'd0);
            check("held_no_reread", 32'(reads.size() - r0), 32'd0);
            check("held_busy", 32'(busy), 32'd1);
        end
        load_a = 1'b0;
        load_b = 1'b0;
        store_tensor = 1'b0;
        cyc = 0;
        while (busy && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        check("release_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_load(input int kind, input logic [15:0] addr, input int hold);
        int rs, lat;
        rs = reads.size();
        run_op(kind, addr, hold, lat);
        check("load_latency", 32'(lat), 32'(N + 2));
        check("load_reads", 32'(reads.size() - rs), 32'(N));
        if (reads.size() - rs == N)
            for (int e = 0; e < N; e++) check("rd_addr", 32'(reads[rs+e]), 32'(16'(addr + e)));
        for (int e = 0; e < N; e++) begin
            if (kind == 0) ra[e] = mem[16'(addr + e)];
            else           rb[e] = mem[16'(addr + e)];
        end
    endtask

    task automatic do_store(input logic [15:0] addr, output int ws);
        int lat;
        logic [31:0] w;
        ws = writes.size();
        run_op(2, addr, 0, lat);
        check("store_latency", 32'(lat), 32'(N*(DIM+1) + 1));
        check("store_writes", 32'(writes.size() - ws), 32'(N));
        chk = '0;
        for (int e = 0; e < N; e++) begin
            chk += ref_c(e);
            if (writes.size() - ws == N) begin
                w = writes[ws+e];
                check("wr_addr", 32'(w[31:16]), 32'(16'(addr + e)));
                check("wr_data", 32'(w[15:0]), 32'(ref_c(e)));
            end
        end
    endtask

    task automatic rez_check(input logic [15:0] exp);
        @(negedge clk);
        str_tensor_rez = 1'b1;
        @(negedge clk);
        str_tensor_rez = 1'b0;
        check("tensor_rez", 32'(tensor_rez), 32'(exp));
    endtask

    initial begin
        logic [15:0] v [N];
        int ws, kind;
        logic [15:0] aa;
        for (int j = 0; j < 65536; j++) mem[j] = '0;
        for (int e = 0; e < N; e++) begin
            ra[e] = '0;
            rb[e] = '0;
        end
        chk = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tensor_op_done), 32'd0);
        check("rst_rd_wr", 32'({mem_rd, mem_wr}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_rez", 32'(tensor_rez), 32'd0);
        reset_n = 1'b1;

        v = '{16'd1, 16'd2, 16'd3, 16'd4};
        put(16'h0010, v);
        do_load(0, 16'h0010, 5);
        v = '{16'd5, 16'd6, 16'd7, 16'd8};
        put(16'h0020, v);
        do_load(1, 16'h0020, 0);
        do_store(16'h0040, ws);
        if (wcyc.size() >= ws + 2) check("write_gap", 32'(wcyc[ws+1] - wcyc[ws]), 32'(DIM + 1));
        rez_check(16'h0086);

        v = '{16'h4000, 16'h4000, 16'h0000, 16'h0000};
        put(16'h0030, v);
        do_load(0, 16'h0030, 0);
        v = '{16'h0002, 16'h0000, 16'h0002, 16'h0000};
        put(16'h0034, v);
        do_load(1, 16'h0034, 0);
        do_store(16'h0050, ws);
        aa = writes[ws][15:0];
`ifdef TENSOR_SATURATE_EN
        check("sat_c00", 32'(aa), 32'h7FFF);
`else
        check("wrap_c00", 32'(aa), 32'h0000);
`endif

        v = '{16'd9, 16'd10, 16'd11, 16'd12};
        put(16'h0060, v);
        do_load(3, 16'h0060, 0);
        do_store(16'h0070, ws);
        rez_check(chk);

        for (int it = 0; it < 6; it++) begin
            for (int e = 0; e < N; e++)
                v[e] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 20) - 10);
            aa = (it == 0) ? 16'hFFFE : 16'($urandom);
            put(aa, v);
            kind = $urandom_range(0, 2);
            do_load(kind == 2 ? 3 : kind, aa, $urandom_range(0, 2));
            do_store((it == 1) ? 16'hFFFF : 16'($urandom), ws);
            rez_check(chk);
        end

        @(negedge clk);
        tensor_addr  = 16'h0090;
        store_tensor = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        store_tensor = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_outs", 32'({tensor_op_done, mem_rd, mem_wr}), 32'd0);
        check("arst_bus", 32'({mem_addr, mem_wdata}), 32'd0);
        check("arst_rez", 32'(tensor_rez), 32'd0);
        ws = writes.size();
        repeat (3) @(negedge clk);
        check("arst_no_write", 32'(writes.size() - ws), 32'd0);
        reset_n = 1'b1;
        for (int e = 0; e < N; e++) begin
            ra[e] = '0;
            rb[e] = '0;
        end
        do_store(16'h0090, ws);
        rez_check(16'h0000);

        check("rd_wr_overlap", 32'(both), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tensor_engine.md
Name: tensor_engine

Overview:
- Responder side of the control unit's tensor handshake.
- Accepts level-held LOAD_A, LOAD_B and STORE_TENSOR requests, which the control unit holds while stalled.
- Bursts operand tensors from data memory, computes C = A x B and writes C back to memory.
- Pulses tensor_op_done to release the stall. Sits beside the datapath, sharing the data-memory port while the CPU is stalled.

Parameters:
- DIM, 2, tensor side length; tensors hold DIM*DIM elements, row-major.
- W, 16, element and memory data width.
- AW, 16, memory address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- load_a  in  1  request: load tensor A from tensor_addr
- load_b  in  1  request: load tensor B from tensor_addr
- store_tensor  in  1  request: compute C = A x B, write C to tensor_addr
- str_tensor_rez  in  1  one-cycle: latch checksum into tensor_rez
- tensor_addr  in  AW  base address, sampled at request acceptance
- tensor_op_done  out  1  one-cycle completion pulse
- busy  out  1  high in any state other than IDLE
- mem_addr  out  AW  memory address
- mem_rd  out  1  read strobe; mem_rdata is valid the following cycle
- mem_rdata  in  W  read data
- mem_wr  out  1  write strobe
- mem_wdata  out  W  write data
- tensor_rez  out  W  checksum register

Behaviour:
- Reset, asynchronous on reset_n low, effective mid-operation:
  - State goes to IDLE.
  - Internal A, B, index and checksum registers clear to 0.
  - All outputs are 0.
- States: IDLE, LOAD, LOAD_LAST, MAC, WRITE, DONE, RELEASE.
- IDLE: accepts a request on a clock edge where it is high.
  - Priority: load_b > load_a > store_tensor.
  - Latches tensor_addr and the operation; index i = 0.
  - str_tensor_rez high in IDLE: tensor_rez <= checksum on the next edge. Ignored in every other state.
- LOAD (i = 0..N-1, N = DIM*DIM):
  - Drives mem_rd=1, mem_addr = base + i.
  - The word returned for i-1 is written to element i-1 of A or B.
  - After i = N-1, goes to LOAD_LAST, which captures element N-1 with no read strobe.
  - Total LOAD+LOAD_LAST = N+1 cycles.
- Store path, for each output element (r,c) in row-major order:
  - MAC runs DIM cycles: acc += A[r][k]*B[k][c], k = 0..DIM-1.
  - Products are signed W x W -> 2W. acc is 2W+clog2(DIM) bits and is cleared at the start of each element.
  - WRITE runs 1 cycle: mem_wr=1, mem_addr = base + r*DIM + c, mem_wdata = result (see Optional Feature).
  - In WRITE, checksum <= checksum + result, modulo 2^W. The checksum is cleared when a store is accepted.
  - After the last element, goes to DONE.
- DONE: tensor_op_done=1 for exactly one cycle, then RELEASE.
- RELEASE: waits until load_a, load_b and store_tensor are all low, then IDLE.
  - This prevents re-triggering from the request still being held in the cycle done is observed.
- Requests that change or arrive while busy are ignored; only the latched operation proceeds.
- mem_rd and mem_wr are never high together, and both are 0 outside LOAD/WRITE.
- Address arithmetic wraps modulo 2^AW.
- Latency:
  - Load: done in cycle N+2 after acceptance.
  - Store: done after N*(DIM+1)+1 cycles.

Optional Feature:
- Macro TENSOR_SATURATE_EN.
- Defined: WRITE result is acc saturated to the signed W-bit range (0x7FFF / 0x8000 for W=16).
- Undefined: result = acc[W-1:0], two's-complement wrap.
- The checksum is always modulo 2^W.

Decomposition:
- Package tensor_pkg holds:
  - the state enum
  - the op encoding (OP_LOAD_A, OP_LOAD_B, OP_STORE)
  - DIM/W defaults
  - the saturation limit constants
- One sub-module, tensor_mac:
  - signed multiply-accumulate with clear and enable
  - exposes acc and the W-bit result, including optional saturation.

Test Plan:
- Load A from addr 0x0010 holding 1,2,3,4:
  - mem_rd high 4 cycles at 0x10..0x13.
  - tensor_op_done pulses once at cycle 6 after acceptance.
  - busy drops after load_a is released.
- Load A = [1,2,3,4], B = [5,6,7,8], store to 0x0040:
  - Writes 19, 22, 43, 50 at 0x40..0x43, one per 3 cycles.
  - Then str_tensor_rez sets tensor_rez = 134 (0x0086).
- A row0 = 0x4000,0x4000; B col0 = 0x0002,0x0002; store:
  - C[0][0] = 0x0000 without TENSOR_SATURATE_EN.
  - C[0][0] = 0x7FFF with it.
- load_a held 5 cycles after done:
  - Exactly one done pulse and no second read burst.
  - A new request is accepted only after all requests go low.
- load_a and load_b asserted together:
  - B is loaded; A is unchanged, checked by a subsequent store result.
- reset_n low during the store MAC phase:
  - All outputs are 0 immediately, with no further mem_wr.
  - After release, a store writes 0,0,0,0 because A and B were cleared.
